// File: rtl/ifm_pingpong_arbiter_pkg.sv
// Shared encodings and size helpers for the two-bank IFM ping-pong scheduler.
package ifm_pingpong_arbiter_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY = 2'b00,
    BANK_FILL  = 2'b01,
    BANK_FULL  = 2'b10,
    BANK_READ  = 2'b11
  } bank_state_t;

  typedef enum logic {
    C_IDLE = 1'b0,
    C_BUSY = 1'b1
  } cons_state_t;

  function automatic int calcWords(input int ifmSize, input int ifmDepth);
    return ifmSize * ifmSize * ifmDepth;
  endfunction

  // A single-word bank still needs a one-bit address port.
  function automatic int calcAddrBits(input int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

  // FULL and READ both hold data the consumer has not released yet.
  function automatic logic bankHeld(input bank_state_t s);
    return (s == BANK_FULL) || (s == BANK_READ);
  endfunction

endpackage

// File: rtl/ifm_pingpong_arbiter_wrap_counter.sv
// Modulo-N counter with enable, synchronous clear and a terminal-count tick.
module ifm_wrap_counter #(
  parameter int N = 16,
  parameter int W = (N <= 1) ? 1 : $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_enable,
  output logic [W-1:0] o_count,
  output logic         o_tick
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] r_count;

  assign o_count = r_count;
  assign o_tick  = i_enable && (r_count == LAST);

  // Wrap explicitly at N-1 so non-power-of-two moduli never reach N.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/ifm_pingpong_arbiter.sv
// Ping-pong IFM bank scheduler: write addressing, bank occupancy and consumer handshake.
module ifm_pingpong_arbiter
  import ifm_pingpong_arbiter_pkg::*;
#(
  parameter int IFM_SIZE     = 28,
  parameter int IFM_DEPTH    = 6,
  parameter int WORDS        = calcWords(IFM_SIZE, IFM_DEPTH),
  parameter int ADDRESS_SIZE = calcAddrBits(WORDS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en_in,
  input  logic                    end_from_next,
  output logic                    wr_ready,
  output logic                    wr_enable,
  output logic                    wr_bank_sel,
  output logic [ADDRESS_SIZE-1:0] wr_address,
  output logic                    rd_bank_sel,
  output logic                    start_to_next,
  output logic [1:0]              occupancy,
  output logic                    err_overflow
);

  bank_state_t r_bankState [2];
  logic        r_wbank;
  logic        r_rbank;
  cons_state_t r_consState;
  logic        r_errOverflow;

  logic                    w_wrReady;
  logic                    w_wrEnable;
  logic                    w_lastWrite;
  logic                    w_start;
  logic [ADDRESS_SIZE-1:0] w_count;

  assign w_wrReady  = (r_bankState[r_wbank] == BANK_EMPTY) ||
                      (r_bankState[r_wbank] == BANK_FILL);
  assign w_wrEnable = wr_en_in && w_wrReady;
  assign w_start    = (r_consState == C_IDLE) && (r_bankState[r_rbank] == BANK_FULL);

  assign wr_ready      = w_wrReady;
  assign wr_enable     = w_wrEnable;
  assign wr_bank_sel   = r_wbank;
  assign wr_address    = w_count;
  assign rd_bank_sel   = r_rbank;
  assign start_to_next = w_start;
  assign occupancy     = 2'(bankHeld(r_bankState[0])) + 2'(bankHeld(r_bankState[1]));
  assign err_overflow  = r_errOverflow;

  ifm_wrap_counter #(
    .N (WORDS),
    .W (ADDRESS_SIZE)
  ) u_addrCounter (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (1'b0),
    .i_enable (w_wrEnable),
    .o_count  (w_count),
    .o_tick   (w_lastWrite)
  );

  // Writer only touches EMPTY/FILL banks, consumer only FULL/READ, so both
  // sides may update the bank array in the same cycle without conflict.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bankState[0] <= BANK_EMPTY;
      r_bankState[1] <= BANK_EMPTY;
      r_wbank        <= 1'b0;
      r_rbank        <= 1'b0;
      r_consState    <= C_IDLE;
      r_errOverflow  <= 1'b0;
    end else begin
      if (w_wrEnable) begin
        if (w_lastWrite) begin
          r_bankState[r_wbank] <= BANK_FULL;
          r_wbank              <= ~r_wbank;
        end else if (r_bankState[r_wbank] == BANK_EMPTY) begin
          r_bankState[r_wbank] <= BANK_FILL;
        end
      end

      case (r_consState)
        C_IDLE: begin
          if (w_start) begin
            r_bankState[r_rbank] <= BANK_READ;
            r_consState          <= C_BUSY;
          end
        end
        C_BUSY: begin
          if (end_from_next) begin
            r_bankState[r_rbank] <= BANK_EMPTY;
            r_rbank              <= ~r_rbank;
            r_consState          <= C_IDLE;
          end
        end
      endcase

      if (wr_en_in && !w_wrReady) begin
        r_errOverflow <= 1'b1;
      end
    end
  end

endmodule
